// File: rtl/fp_mult_arbiter.sv
// Round-robin front end sharing one pipelined fp_mult between N_REQ requesters.
// A {valid, id} tag rides alongside each operation so the product returns to its issuer.
module fp_mult_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MUL_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic [N_REQ-1:0]      req,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      gnt,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_q,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_q,
  output logic                  busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;
  logic [PW-1:0] gnt_idx;
  logic          rsp_fire;

  logic          vld_q [MUL_LATENCY];
  logic          vld_d [MUL_LATENCY];
  logic [PW-1:0] id_q  [MUL_LATENCY];
  logic [PW-1:0] id_d  [MUL_LATENCY];

  // (base + off) mod N_REQ; off never exceeds N_REQ, so one subtraction is enough.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[PW-1:0];
  endfunction

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    if (clk_en && !reset) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && req[wrap_add(ptr_q, k)]) begin
          found   = 1'b1;
          gnt_idx = wrap_add(ptr_q, k);
        end
      end
    end
  end

  always_comb begin
    gnt   = '0;
    mul_a = '0;
    mul_b = '0;
    if (found) begin
      gnt[gnt_idx] = 1'b1;
      mul_a        = req_a[32*gnt_idx +: 32];
      mul_b        = req_b[32*gnt_idx +: 32];
    end
  end

  assign ptr_d = found ? wrap_add(gnt_idx, 1) : ptr_q;

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Tag stages advance only on enabled edges, in lockstep with fp_mult.
  generate
    for (genvar gi = 0; gi < MUL_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign vld_d[gi] = found;
        assign id_d[gi]  = gnt_idx;
      end else begin : g_body
        assign vld_d[gi] = vld_q[gi-1];
        assign id_d[gi]  = id_q[gi-1];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q[gi] <= 1'b0;
          id_q[gi]  <= '0;
        end else if (clk_en) begin
          vld_q[gi] <= vld_d[gi];
          id_q[gi]  <= id_d[gi];
        end
      end
    end
  endgenerate

  assign rsp_fire = clk_en && !reset && vld_q[MUL_LATENCY-1];

  always_comb begin
    rsp_valid = '0;
    rsp_q     = '0;
    if (rsp_fire) begin
      rsp_valid[id_q[MUL_LATENCY-1]] = 1'b1;
      rsp_q                          = mul_q;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < MUL_LATENCY; k++) busy = busy | vld_q[k];
  end

endmodule

// File: doc/fp_mult_arbiter.md
# fp_mult_arbiter

Round-robin arbiter that shares one pipelined single-precision `fp_mult` instance between up to `N_REQ` requesters, such as the `fx` evaluator, the CORDIC cosine core and the Nios custom-instruction front end. It grants at most one operation per enabled cycle and drives the multiplier operands. Each issued operation carries a requester tag through a shift pipeline matched to the multiplier latency, so every product is steered back to the requester that issued it. It sits between the requesters and the single `fp_mult` instance in the custom-instruction datapath.

## Interface
- `N_REQ`, default 4: number of requesters, 2–8.
- `MUL_LATENCY`, default 3: `fp_mult` latency in enabled clock edges, ≥1.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high. Also tied to `fp_mult.areset` at the top level.
- `clk_en` in 1: global enable; drives `fp_mult.en` directly.
- `req` in `N_REQ`: per-requester request level. Held high until granted.
- `req_a` in `32*N_REQ`: operand A of requester i at bits [32i+31:32i].
- `req_b` in `32*N_REQ`: operand B, same packing as `req_a`.
- `gnt` out `N_REQ`: one-hot, combinational. Requester i is issued this cycle.
- `mul_a` out 32: operand A to `fp_mult`.
- `mul_b` out 32: operand B to `fp_mult`.
- `mul_q` in 32: `fp_mult` result.
- `rsp_valid` out `N_REQ`: one-hot pulse marking a product returned to requester i.
- `rsp_q` out 32: product, valid when any `rsp_valid` bit is high.
- `busy` out 1: at least one operation is in flight.

## Operation
- **Arbitration.** Round-robin pointer `ptr` (log2 `N_REQ` bits). The search starts at `ptr` and wraps modulo `N_REQ`; the first asserted `req` wins.
  - `gnt` is all-zero when `clk_en`=0 or `reset`=1.
  - On an enabled grant edge to requester g, `ptr` becomes (g+1) mod `N_REQ`. Otherwise `ptr` holds.
- **Operand mux.** `mul_a`/`mul_b` equal the granted requester's `req_a`/`req_b`. With no grant they are 0x00000000, so the pipeline receives 0*0.
- **Tag pipeline.** `MUL_LATENCY` stages, each holding {valid, id}.
  - Stage 0 loads {|gnt, granted index}.
  - All stages shift only on edges where `clk_en`=1, so the pipeline stays aligned with `fp_mult`.
- **Response.**
  - When the last stage is valid and `clk_en`=1: `rsp_valid[id]`=1 and `rsp_q`=`mul_q`. The stage shifts out on that edge, so each response is emitted exactly once.
  - When `clk_en`=0, the last stage holds and `rsp_valid`=0. The response is emitted on the next enabled cycle.
- `rsp_q` is 0x00000000 whenever no `rsp_valid` bit is set.
- `busy` is the OR of all stage valid bits.
- **Requester contract.** A requester drops `req` or presents new operands in the cycle after its `gnt`. Multiple outstanding operations per requester are allowed and return in issue order. No result backpressure: the requester must accept `rsp_valid`.

## Timing
- Reset values: `ptr`=0 and all tag stages invalid. Outputs: `gnt`=0, `rsp_valid`=0, `rsp_q`=0, `busy`=0, `mul_a`/`mul_b`=0.
- Grant is combinational: `req` is sampled and `gnt` asserted in the same cycle T.
- With `clk_en` continuously high, the response appears in cycle T+`MUL_LATENCY`.
- Each `clk_en`=0 cycle adds one cycle of latency.
- Throughput: one issue per enabled cycle, with no bubble between back-to-back grants, including repeat grants to the same requester when it is the only one requesting.
- Simultaneous grant and response in the same cycle is normal pipelined operation and needs no special handling.
- Reset mid-operation flushes all in-flight tags with no responses emitted, and returns `ptr` to 0.
- `req` deasserted before grant is legal; that request is dropped without side effects.

## Test plan
- **Single request.** `req`=0001, `req_a`[0]=0x40000000 (2.0), `req_b`[0]=0x40400000 (3.0) at cycle 5 → `gnt`=0001 at cycle 5; `rsp_valid`=0001 and `rsp_q`=0x40C00000 (6.0) at cycle 8; `busy` high in cycles 6–8.
- **All four simultaneous, held until granted**, with operands i*1.0 times 2.0 → grants in order 0,1,2,3 on consecutive cycles; responses 0x00000000, 0x40000000, 0x40800000, 0x40C00000 on consecutive cycles starting at the first grant +3, each to the matching `rsp_valid` bit.
- **Fairness.** Requesters 1 and 3 both hold `req` with `ptr`=2 → order 3,1,3,1…, with each requester receiving every other grant.
- **Stall.** Grant at cycle 10, then `clk_en`=0 for cycles 11–12 → no grants during the stall; response at cycle 15, emitted exactly once; no `rsp_valid` during the stall.
- **Reset mid-flight.** Three operations issued, then `reset` one cycle later → no `rsp_valid` ever for them; `busy`=0 and `ptr`=0 after reset; a new request after reset is granted to requester 0 when `req`=1111.
- **Idle.** `req`=0 for 20 cycles → `gnt`, `rsp_valid`, `busy` and `rsp_q` all stay 0.
